// File: rtl/registr_serial_tx_module_if.sv
// Word handshake between a producer and the serial frame transmitter.
// The producer (master) offers a word with in_valid; the transmitter
// (slave) signals with in_ready when it can take one.
interface registr_serial_tx_module_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/registr_serial_tx_module.sv
// Parallel-to-serial frame transmitter.
// Frame on the line: start (0), WIDTH data bits MSB first, optional
// even-parity bit, stop (1). Idle line level is 1. A word offered during
// the stop cycle starts the next frame with no idle gap.
module registr_serial_tx_module #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    registr_serial_tx_module_if.slave         bus,
    output logic                              out,
    output logic                              busy
);

    localparam int             CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             par;
    logic             accept;

    // Ready is a pure decode of the state: a word can be taken while idle
    // or during the stop bit (back-to-back frames).
    assign bus.in_ready = (state == IDLE) || (state == STOP);
    assign accept       = bus.in_valid && bus.in_ready;

    // Frame sequencer; out and busy are registered and take the value
    // belonging to the state being entered on each edge.
    // NOTE: every register here uses non-blocking assignment so that all
    // right-hand sides read pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is ordinary flops, not a memory, so
            // clearing it in reset costs nothing and keeps state deterministic.
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            out   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        sh    <= bus.in;
                        par   <= ^bus.in;
                        cnt   <= '0;
                        state <= START;
                        out   <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        out   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                START: begin
                    // First data bit (MSB) goes out; shift so the next
                    // bit sits at the top for the following cycle.
                    state <= DATA;
                    out   <= sh[WIDTH-1];
                    sh    <= {sh[WIDTH-2:0], 1'b0};
                    busy  <= 1'b1;
                end

                DATA: begin
                    busy <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (PARITY_EN) begin
                            state <= PARITY;
                            out   <= par;
                        end else begin
                            state <= STOP;
                            out   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        out <= sh[WIDTH-1];
                        sh  <= {sh[WIDTH-2:0], 1'b0};
                    end
                end

                PARITY: begin
                    state <= STOP;
                    out   <= 1'b1;
                    busy  <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    out   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_registr_serial_tx_module.sv
// Self-checking bench for registr_serial_tx_module. Two instances run side
// by side: 8-bit with parity and 4-bit without. Stimulus pushes the
// expected frame contents into per-instance queues; independent line
// monitors decode each frame off the serial line and compare.
module tb_registr_serial_tx_module;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } frame8_t;

    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    logic out8, busy8;
    logic out4, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    frame8_t    q8[$];
    logic [3:0] q4[$];

    registr_serial_tx_module_if #(.WIDTH(8)) bus8 ();
    registr_serial_tx_module_if #(.WIDTH(4)) bus4 ();

    registr_serial_tx_module #(.WIDTH(8), .PARITY_EN(1'b1)) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
        .bus  (bus8),
        .out  (out8),
        .busy (busy8)
    );

    registr_serial_tx_module #(.WIDTH(4), .PARITY_EN(1'b0)) u_dut4 (
        .clk  (clk),
        .rst  (rst4),
        .bus  (bus4),
        .out  (out4),
        .busy (busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: 8-bit line with parity ----------------
    int         pos8 = -1;
    logic [7:0] data8;
    logic       par8;
    logic       busy_ok8;

    always @(negedge clk) begin
        frame8_t e;
        if (rst8 === 1'b1) begin
            pos8 = -1;
        end else if (pos8 < 0) begin
            if (out8 === 1'b0) begin
                pos8     = 0;
                data8    = '0;
                busy_ok8 = (busy8 === 1'b1);
            end
        end else if (pos8 < 8) begin
            data8    = {data8[6:0], out8};
            busy_ok8 = busy_ok8 && (busy8 === 1'b1);
            pos8++;
        end else if (pos8 == 8) begin
            par8     = out8;
            busy_ok8 = busy_ok8 && (busy8 === 1'b1);
            pos8++;
        end else begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame8_unexpected: got frame %h, expected none", data8);
            end else begin
                e = q8.pop_front();
                check("frame8_data", data8, e.data);
                check("frame8_parity", par8, e.par);
                check("frame8_stop", out8, 1);
                check("frame8_busy", busy_ok8 && (busy8 === 1'b1), 1);
            end
            pos8 = -1;
        end
    end

    // ---------------- monitor: 4-bit line, no parity ----------------
    int         pos4 = -1;
    logic [3:0] data4;

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst4 === 1'b1) begin
            pos4 = -1;
        end else if (pos4 < 0) begin
            if (out4 === 1'b0) begin
                pos4  = 0;
                data4 = '0;
            end
        end else if (pos4 < 4) begin
            data4 = {data4[2:0], out4};
            pos4++;
        end else begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame4_unexpected: got frame %h, expected none", data4);
            end else begin
                e = q4.pop_front();
                check("frame4_data", data4, e);
                check("frame4_stop", out4, 1);
            end
            pos4 = -1;
        end
    end

    // ---------------- stimulus: 8-bit instance ----------------
    task automatic run8();
        // Reset held for 3 edges with a word already offered.
        rst8          = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.in       = 8'hA5;
        q8.push_back('{data: 8'hA5, par: 1'b0});
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out", out8, 1);
            check("rst_busy", busy8, 0);
            check("rst_ready", bus8.in_ready, 1);
        end
        rst8 = 1'b0;

        // Single frame A5: ready low 10 cycles, busy high 11.
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) check("a5_start_bit", out8, 0);
            check($sformatf("a5_ready_c%0d", c), bus8.in_ready, (c >= 10) ? 1 : 0);
            check($sformatf("a5_busy_c%0d", c), busy8, (c <= 10) ? 1 : 0);
        end
        check("a5_idle_out", out8, 1);

        // Back-to-back FF then 01 with in_valid held high.
        bus8.in       = 8'hFF;
        bus8.in_valid = 1'b1;
        q8.push_back('{data: 8'hFF, par: 1'b0});
        @(posedge clk);
        #1 bus8.in = 8'h01;
        q8.push_back('{data: 8'h01, par: 1'b1});
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            if (c == 10) begin
                check("b2b_stop_out", out8, 1);
                check("b2b_stop_ready", bus8.in_ready, 1);
            end
            if (c == 11) begin
                check("b2b_no_gap_start", out8, 0);
                check("b2b_no_gap_busy", busy8, 1);
                bus8.in_valid = 1'b0;
            end
            if (c == 22) begin
                check("b2b_idle_busy", busy8, 0);
                check("b2b_idle_out", out8, 1);
            end
        end

        // Data stability: C3 accepted, input changes to 00 two cycles later;
        // 00 is then taken at the stop cycle.
        bus8.in       = 8'hC3;
        bus8.in_valid = 1'b1;
        q8.push_back('{data: 8'hC3, par: 1'b0});
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 bus8.in = 8'h00;
        q8.push_back('{data: 8'h00, par: 1'b0});
        repeat (9) @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("stab_idle_busy", busy8, 0);

        // Mid-frame reset during data bit 3 of A5; that frame is dropped.
        bus8.in       = 8'hA5;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst8 = 1'b1;
        @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        check("midrst_out", out8, 1);
        check("midrst_busy", busy8, 0);
        check("midrst_ready", bus8.in_ready, 1);

        // Following 3C frame must be intact.
        bus8.in       = 8'h3C;
        bus8.in_valid = 1'b1;
        q8.push_back('{data: 8'h3C, par: 1'b0});
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_idle_busy", busy8, 0);
    endtask

    // ---------------- stimulus: 4-bit instance ----------------
    task automatic run4();
        logic [6:0] exp_line;
        rst4          = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.in       = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst4 = 1'b0;

        // 1011 -> 0,1,0,1,1,1 then idle; six-cycle frame.
        exp_line      = 7'b0101111;
        bus4.in       = 4'b1011;
        bus4.in_valid = 1'b1;
        q4.push_back(4'b1011);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("w4_out_c%0d", c), out4, exp_line[6-c]);
            check($sformatf("w4_busy_c%0d", c), busy4, (c <= 5) ? 1 : 0);
            check($sformatf("w4_ready_c%0d", c), bus4.in_ready, (c >= 5) ? 1 : 0);
        end

        // Second word, decoded by the monitor only.
        bus4.in       = 4'b0110;
        bus4.in_valid = 1'b1;
        q4.push_back(4'b0110);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("w4_idle_busy", busy4, 0);
    endtask

    initial begin
        fork
            run8();
            run4();
        join
        repeat (2) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/registr_serial_tx_module.md
# registr_serial_tx_module

Parallel-to-serial frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single-bit line, one bit per clock. Each frame is a start bit, the data bits MSB first, an optional even-parity bit and a stop bit. It is the sending end of the single-bit serial link whose receiving end is the serial-in shift-register chain. Back-to-back frames are supported with no idle gap.

## Interface
- WIDTH, 8, data word width; must be ≥ 2.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in  input  WIDTH  word to transmit; sampled only on the accepting edge.
- in_valid  input  1  `in` holds a word to send.
- in_ready  output  1  block can accept a word this cycle.
- out  output  1  serial line; idle level 1; registered.
- busy  output  1  a frame is in progress (state ≠ IDLE); registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Internal resources:
  - WIDTH-bit shift register `sh`.
  - Bit counter `cnt`, wide enough for 0..WIDTH-1.
  - Parity accumulator `par`.
- Accept event: `in_valid & in_ready` at a rising edge. On accept:
  - `sh <= in`, `par <= ^in`, `cnt <= 0`.
  - Next state is START.
- in_ready = 1 in IDLE and STOP; 0 in START, DATA and PARITY. It is a combinational decode of the state register.
- Line level by state:
  - IDLE: out = 1.
  - START: out = 0.
  - DATA: out = `sh[WIDTH-1]`; `sh` shifts left by one bit per cycle.
  - PARITY: out = `par`, so the total count of ones across data and parity is even.
  - STOP: out = 1.
- Transitions:
  - IDLE → START on accept; otherwise stay in IDLE.
  - START → DATA.
  - DATA → DATA while cnt < WIDTH-1 (cnt increments each cycle). When cnt = WIDTH-1: go to PARITY if PARITY_EN, else STOP.
  - PARITY → STOP.
  - STOP → START on accept (back-to-back frame); otherwise → IDLE.
- `in` and `in_valid` are ignored while in_ready = 0. A word held on `in` during a frame is not lost; it is accepted at the STOP cycle.
- Reset, including mid-frame:
  - Next state is IDLE; any partial frame is discarded.
  - out = 1, busy = 0, in_ready = 1, `sh` = 0, `cnt` = 0, `par` = 0.
- rst has priority over an accept in the same cycle; that word is not taken.

## Timing
- Reset values: out = 1, busy = 0, in_ready = 1.
- Output registering: out and busy are registered; each value appears after the edge that enters the state.
- Frame for an accept at edge k:
  - Start bit (out = 0) during the cycle after edge k.
  - Data bit i (i = 0 is the MSB) during the cycle after edge k+1+i.
  - Parity bit after edge k+1+WIDTH.
  - Stop bit after edge k+1+WIDTH+PARITY_EN.
- Frame length is F = WIDTH + PARITY_EN + 2 cycles. Latency from accept edge to first line change is 1 cycle.
- Back-to-back operation:
  - An accept during STOP makes the next start bit follow the stop bit directly.
  - Sustained throughput is one word per F cycles.
  - busy stays 1 across the frame boundary.
- Without a STOP-cycle accept, the block returns to IDLE: busy = 0, out = 1 from edge k+F onward.

## Test plan
- Reset: assert rst for 3 cycles with in_valid = 1 → out = 1, busy = 0, in_ready = 1 throughout; no frame starts until the first edge after rst = 0.
- Single frame, WIDTH = 8, PARITY_EN = 1, in = 8'hA5 accepted at edge k:
  - out on successive cycles = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop).
  - in_ready = 0 for 10 cycles, then 1; busy = 1 for 11 cycles.
- Back-to-back: 8'hFF, then 8'h01 presented with in_valid held high:
  - out = 0,11111111,0,1 then 0,00000001,1,1.
  - No idle cycle between the frames; the second word is accepted exactly at the first frame's STOP cycle.
- Data stability: change `in` to 8'h00 two cycles after accepting 8'hC3 → transmitted bits remain 11000011 with parity 0.
- Mid-frame reset: send 8'hA5, assert rst for 1 cycle during data bit 3 → next cycle out = 1, busy = 0, in_ready = 1. A subsequent 8'h3C frame is transmitted intact.
- Parity disabled: WIDTH = 4, PARITY_EN = 0, in = 4'b1011 → out = 0,1,0,1,1,1; frame length is 6 cycles.
